// File: rtl/shift_rotate_pipe.sv
// Pipelined barrel shifter/rotator with valid/ready handshakes.
// Supports LSL, LSR, ASR, ROR, RRX and an even-amount immediate rotate.
module shift_rotate_pipe #(
  parameter int WIDTH = 32,
  parameter int STAGES = 2,
  localparam int AMTW = $clog2(WIDTH) + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [AMTW-1:0]  b,
  input  logic [2:0]       mode,
  input  logic             carry_in,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] z,
  output logic             carry_out,
  output logic             illegal
);

  localparam int LW = $clog2(WIDTH);

  typedef enum logic [2:0] {
    OP_LSL,
    OP_LSR,
    OP_ASR,
    OP_ROR,
    OP_RRX,
    OP_IMM,
    OP_ILL
  } op_t;

  op_t             op_in;
  logic [AMTW-1:0] amt_in;
  logic            en;

  assign en = !out_valid || out_ready;
  assign in_ready = en && !rst;

  always_comb begin
    op_in = OP_ILL;
    amt_in = b;
    unique case (1'b1)
      (mode == 3'b000): op_in = OP_LSL;
      (mode == 3'b001): op_in = OP_LSR;
      (mode == 3'b010): op_in = OP_ASR;
      (mode == 3'b011): op_in = OP_ROR;
      (mode == 3'b100): op_in = OP_RRX;
      (mode == 3'b101): begin
        op_in = OP_IMM;
        amt_in = AMTW'({b[LW-2:0], 1'b0});
      end
      default: op_in = OP_ILL;
    endcase
  end

  // Result packed as {illegal, carry, z}; double-width shifts land the
  // carry bit at a fixed position for every in-range and oversize amount.
  function automatic logic [WIDTH+1:0] calc(
    input op_t             op,
    input logic [AMTW-1:0] n,
    input logic [WIDTH-1:0] x,
    input logic            ci
  );
    logic [2*WIDTH-1:0] t;
    logic [WIDTH-1:0]   r;
    logic               c;
    logic               il;
    t = {x, x} >> n[LW-1:0];
    r = x;
    c = ci;
    il = 1'b0;
    unique case (op)
      OP_LSL: if (n != '0) begin
        t = {{WIDTH{1'b0}}, x} << n;
        r = t[WIDTH-1:0];
        c = t[WIDTH];
      end
      OP_LSR: if (n != '0) begin
        t = {x, {WIDTH{1'b0}}} >> n;
        r = t[2*WIDTH-1:WIDTH];
        c = t[WIDTH-1];
      end
      OP_ASR: if (n != '0) begin
        t = $signed({x, {WIDTH{1'b0}}}) >>> n;
        r = t[2*WIDTH-1:WIDTH];
        c = t[WIDTH-1];
      end
      OP_ROR, OP_IMM: if (n != '0) begin
        r = t[WIDTH-1:0];
        c = r[WIDTH-1];
      end
      OP_RRX: begin
        r = {ci, x[WIDTH-1:1]};
        c = x[0];
      end
      default: il = 1'b1;
    endcase
    return {il, c, r};
  endfunction

  if (STAGES == 2) begin : g_two
    op_t              s1_op;
    logic [AMTW-1:0]  s1_amt;
    logic [WIDTH-1:0] s1_a;
    logic             s1_cin;
    logic             s1_valid;
    logic [WIDTH+1:0] res;

    assign res = calc(s1_op, s1_amt, s1_a, s1_cin);

    always_ff @(posedge clk) begin
      if (rst) begin
        s1_valid <= 1'b0;
        out_valid <= 1'b0;
        z <= '0;
        carry_out <= 1'b0;
        illegal <= 1'b0;
      end else if (en) begin
        s1_valid <= in_valid;
        if (in_valid) begin
          s1_op <= op_in;
          s1_amt <= amt_in;
          s1_a <= a;
          s1_cin <= carry_in;
        end
        out_valid <= s1_valid;
        if (s1_valid) {illegal, carry_out, z} <= res;
      end
    end
  end else begin : g_one
    logic [WIDTH+1:0] res;

    assign res = calc(op_in, amt_in, a, carry_in);

    always_ff @(posedge clk) begin
      if (rst) begin
        out_valid <= 1'b0;
        z <= '0;
        carry_out <= 1'b0;
        illegal <= 1'b0;
      end else if (en) begin
        out_valid <= in_valid;
        if (in_valid) {illegal, carry_out, z} <= res;
      end
    end
  end

endmodule

// File: doc/shift_rotate_pipe.md
SHIFT_ROTATE_PIPE -- requirements
Module: shift_rotate_pipe

Interface
REQ-001 The block SHALL have parameter WIDTH, default 32, meaning operand width; legal values are powers of two from 8 to 64.
REQ-002 The block SHALL have parameter STAGES, default 2, meaning the number of register stages; legal values are 1 and 2.
REQ-003 The block SHALL use derived constant AMTW = clog2(WIDTH)+1 as the shift-amount width.
REQ-004 The block SHALL use one clock and a synchronous, active-high reset.
REQ-005 Ports:
- clk  input  1  clock; all state changes on the rising edge.
- rst  input  1  synchronous active-high reset.
- in_valid  input  1  an operation is presented.
- in_ready  output  1  the block can accept an operation this cycle.
- a  input  WIDTH  operand.
- b  input  AMTW  shift amount (unsigned).
- mode  input  3  operation select.
- carry_in  input  1  incoming carry flag.
- out_valid  output  1  z, carry_out and illegal hold a result.
- out_ready  input  1  the consumer takes the result this cycle.
- z  output  WIDTH  result.
- carry_out  output  1  shifter carry.
- illegal  output  1  the result came from an unsupported mode.

Function
REQ-006 Transfer rules:
- An input is accepted on a cycle with in_valid && in_ready.
- A result is consumed on a cycle with out_valid && out_ready.
REQ-007 Pipeline advance:
- Advance enable en = !out_valid || out_ready.
- in_ready SHALL equal en, forced to 0 while rst is high.
- All stages advance together when en is 1; bubbles are not collapsed.
REQ-008 Latency: when not stalled, a result SHALL appear on out_valid exactly STAGES cycles after acceptance.
REQ-009 While out_valid && !out_ready, z, carry_out and illegal SHALL hold stable.
REQ-010 Results SHALL leave in acceptance order, with no loss or duplication.
REQ-011 Mode 000, LSL by n=b:
- n=0: z=a, c=carry_in.
- 1..W-1: z=a<<n, c=a[W-n].
- n=W: z=0, c=a[0].
- n>W: z=0, c=0.
REQ-012 Mode 001, LSR by n=b:
- n=0: z=a, c=carry_in.
- 1..W-1: z=a>>n, c=a[n-1].
- n=W: z=0, c=a[W-1].
- n>W: z=0, c=0.
REQ-013 Mode 010, ASR by n=b:
- n=0: z=a, c=carry_in.
- 1..W-1: arithmetic right shift, c=a[n-1].
- n>=W: every bit of z equals a[W-1], c=a[W-1].
REQ-014 Mode 011, ROR by n=b, with r = n mod W:
- n=0: z=a, c=carry_in.
- n!=0 and r=0: z=a, c=a[W-1].
- otherwise: z = a rotated right by r, c=a[r-1].
REQ-015 Mode 100, RRX:
- z={carry_in, a[W-1:1]}, c=a[0].
- b is ignored.
REQ-016 Mode 101, immediate rotate, with r = 2*(b mod (W/2)):
- r=0: z=a, c=carry_in.
- otherwise: z = a rotated right by r, c=z[W-1].
REQ-017 Modes 110 and 111: z=a, c=carry_in, illegal=1; illegal SHALL be 0 for all other modes.
REQ-018 Split point:
- STAGES=2: stage 1 registers the decoded mode, effective amount, operand and carry_in; stage 2 registers z, carry_out and illegal.
- STAGES=1: everything is registered in one stage.
REQ-019 Outputs SHALL be driven only from registers, with no combinational path from a, b or mode to z.

Reset
REQ-020 On a clock edge with rst=1, all stage valid bits SHALL clear and out_valid, z, carry_out and illegal SHALL become 0.
REQ-021 Reset asserted mid-operation SHALL discard all in-flight operations; no stale result SHALL appear after rst deasserts.
REQ-022 The first acceptance is possible on the first edge after rst deasserts.

Verification (WIDTH=32, STAGES=2)
REQ-023 Mode 101, a=0x000000FF, b=4, out_ready=1 -> two cycles later out_valid=1, z=0xFF000000, carry_out=1, illegal=0.
REQ-024 Mode 000, a=0x80000001:
- b=32 -> z=0, carry_out=1.
- b=33 -> z=0, carry_out=0.
- b=0 with carry_in=1 -> z=0x80000001, carry_out=1.
REQ-025 Mode 010, a=0x80000000, b=40 -> z=0xFFFFFFFF, carry_out=1. Mode 100, a=0x00000003, carry_in=1 -> z=0x80000001, carry_out=1.
REQ-026 Backpressure:
- Stimulus: three back-to-back LSR operations, a=0x10, b=1/2/3, with out_ready=0 for 3 cycles after the first result.
- Response: in_ready=0 while stalled, z held at 0x8; then 0x8, 0x4, 0x2 delivered in order, once each.
REQ-027 rst pulsed for one cycle with two operations in flight -> next cycle out_valid=0, z=0; neither result ever appears.
REQ-028 Mode 111, a=0x12345678, carry_in=0 -> z=0x12345678, carry_out=0, illegal=1.
